// File: rtl/message_transmitter_pkg.sv
// Shared types and constants for the CAN frame transmitter.
// Bit polarity everywhere: 1 is dominant, 0 is recessive.
package message_transmitter_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID_A,
    ST_SRR,
    ST_IDE,
    ST_ID_B,
    ST_RTR,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } tx_state_t;

  localparam logic [6:0] LEN_ID_A = 7'd11;
  localparam logic [6:0] LEN_ID_B = 7'd18;
  localparam logic [6:0] LEN_DLC  = 7'd4;
  localparam logic [6:0] LEN_CRC  = 7'd15;
  localparam logic [6:0] LEN_EOF  = 7'd7;
  localparam logic [6:0] LEN_IFS  = 7'd3;

  localparam logic DOMINANT  = 1'b1;
  localparam logic RECESSIVE = 1'b0;

  // Remote frames carry no data; DLC values above 8 still mean 8 bytes.
  function automatic logic [3:0] data_bytes(input logic [3:0] dlc, input logic rtr);
    if (rtr)
      return 4'd0;
    else if (dlc > 4'd8)
      return 4'd8;
    else
      return dlc;
  endfunction

endpackage

// File: rtl/crc_step_machine.sv
// CAN CRC-15 (polynomial 0x4599), advanced by one frame bit per update_crc.
module crc_step_machine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_crc,
  input  logic        update_crc,
  input  logic        crc_bit,
  output logic [14:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= 15'd0;
    else if (clear_crc)
      crc <= 15'd0;
    else if (update_crc)
      crc <= {crc[13:0], 1'b0} ^ ((crc_bit ^ crc[14]) ? 15'h4599 : 15'h0000);
  end

endmodule

// File: rtl/message_transmitter.sv
// CAN frame serializer: latches a frame request and offers the unstuffed
// frame bit by bit to the transmit pipeline, checking the bus readback.
module message_transmitter
  import message_transmitter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_req,
  input  logic [28:0] msg_id,
  input  logic        extended,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] msg,
  input  logic        bus_idle,
  input  logic        bit_advance,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  output logic        next_bit,
  output logic        stuff_bypass,
  output logic        tx_busy,
  output logic        tx_ack,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        bit_error,
  output logic        ack_error
);

  tx_state_t   state, state_n;
  logic [6:0]  cnt, cnt_n;
  logic [28:0] id_q;
  logic        ext_q, rtr_q;
  logic [3:0]  dlc_q, bytes_q;
  logic [63:0] msg_q;
  logic [14:0] crc, crc_hold, crc_src;
  logic [10:0] base_id;
  logic [2:0]  lead_bytes;
  logic [5:0]  data_idx;
  logic        update_crc, clear_crc;
  logic        accept, in_arb, load, bit_n;
  logic        arb_fail, bit_fail, ack_fail, abort, last_bit;

  crc_step_machine u_crc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_crc  (clear_crc),
    .update_crc (update_crc),
    .crc_bit    (next_bit),
    .crc        (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 7'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Readback compare uses the bit already on the bus; an error beats a same-cycle advance.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    arb_fail = 1'b0;
    bit_fail = 1'b0;
    ack_fail = 1'b0;
    last_bit = 1'b0;
    if (state != ST_IDLE && rx_bit_valid) begin
      if (state == ST_ACK_SLOT)
        ack_fail = (rx_bit == RECESSIVE);
      else if (rx_bit != next_bit) begin
        if (in_arb && next_bit == RECESSIVE)
          arb_fail = 1'b1;
        else
          bit_fail = 1'b1;
      end
    end
    abort = arb_fail | bit_fail | ack_fail;

    if (state == ST_IDLE) begin
      if (accept) begin
        state_n = ST_SOF;
        cnt_n   = 7'd0;
      end
    end else if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = 7'd0;
    end else if (bit_advance) begin
      if (cnt != 7'd0)
        cnt_n = cnt - 7'd1;
      else begin
        cnt_n = 7'd0;
        case (state)
          ST_SOF:      begin state_n = ST_ID_A; cnt_n = LEN_ID_A - 7'd1; end
          ST_ID_A:     state_n = ext_q ? ST_SRR : ST_RTR;
          ST_SRR:      state_n = ST_IDE;
          ST_IDE: begin
            if (ext_q) begin
              state_n = ST_ID_B;
              cnt_n   = LEN_ID_B - 7'd1;
            end else
              state_n = ST_R0;
          end
          ST_ID_B:     state_n = ST_RTR;
          ST_RTR:      state_n = ext_q ? ST_R1 : ST_IDE;
          ST_R1:       state_n = ST_R0;
          ST_R0:       begin state_n = ST_DLC; cnt_n = LEN_DLC - 7'd1; end
          ST_DLC: begin
            if (bytes_q == 4'd0) begin
              state_n = ST_CRC;
              cnt_n   = LEN_CRC - 7'd1;
            end else begin
              state_n = ST_DATA;
              cnt_n   = {bytes_q, 3'b000} - 7'd1;
            end
          end
          ST_DATA:     begin state_n = ST_CRC; cnt_n = LEN_CRC - 7'd1; end
          ST_CRC:      state_n = ST_CRC_DEL;
          ST_CRC_DEL:  state_n = ST_ACK_SLOT;
          ST_ACK_SLOT: state_n = ST_ACK_DEL;
          ST_ACK_DEL:  begin state_n = ST_EOF; cnt_n = LEN_EOF - 7'd1; end
          ST_EOF:      begin state_n = ST_IFS; cnt_n = LEN_IFS - 7'd1; end
          ST_IFS:      begin state_n = ST_IDLE; last_bit = 1'b1; end
          default:     state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    accept       = (state == ST_IDLE) && tx_req && bus_idle;
    clear_crc    = accept;
    tx_busy      = (state != ST_IDLE);
    stuff_bypass = (state == ST_IDLE) || (state >= ST_CRC_DEL);
    in_arb       = (state >= ST_ID_A) && (state <= ST_RTR);
    load         = accept || ((state != ST_IDLE) && bit_advance);
  end

  // Value of the bit that will be on the bus once state_n/cnt_n take effect.
  always_comb begin
    base_id    = ext_q ? id_q[28:18] : id_q[10:0];
    lead_bytes = 3'd0 - bytes_q[2:0];
    data_idx   = {lead_bytes, 3'b000} + cnt_n[5:0];
    crc_src    = (state == ST_CRC) ? crc_hold : crc;
    case (state_n)
      ST_SOF:  bit_n = DOMINANT;
      ST_ID_A: bit_n = base_id[cnt_n[3:0]];
      ST_SRR:  bit_n = RECESSIVE;
      ST_IDE:  bit_n = ext_q ? RECESSIVE : DOMINANT;
      ST_ID_B: bit_n = id_q[cnt_n[4:0]];
      ST_RTR:  bit_n = ~rtr_q;
      ST_R1:   bit_n = DOMINANT;
      ST_R0:   bit_n = DOMINANT;
      ST_DLC:  bit_n = dlc_q[cnt_n[1:0]];
      ST_DATA: bit_n = msg_q[data_idx];
      ST_CRC:  bit_n = crc_src[cnt_n[3:0]];
      default: bit_n = RECESSIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_bit   <= RECESSIVE;
      update_crc <= 1'b0;
      tx_ack     <= 1'b0;
      tx_done    <= 1'b0;
      arb_lost   <= 1'b0;
      bit_error  <= 1'b0;
      ack_error  <= 1'b0;
      id_q       <= 29'd0;
      ext_q      <= 1'b0;
      rtr_q      <= 1'b0;
      dlc_q      <= 4'd0;
      bytes_q    <= 4'd0;
      msg_q      <= 64'd0;
      crc_hold   <= 15'd0;
    end else begin
      tx_ack     <= accept;
      tx_done    <= last_bit;
      arb_lost   <= arb_fail;
      bit_error  <= bit_fail;
      ack_error  <= ack_fail;
      update_crc <= 1'b0;
      if (accept) begin
        id_q    <= msg_id;
        ext_q   <= extended;
        rtr_q   <= rtr;
        dlc_q   <= dlc;
        bytes_q <= data_bytes(dlc, rtr);
        msg_q   <= msg;
      end
      if (abort)
        next_bit <= RECESSIVE;
      else if (load) begin
        next_bit   <= bit_n;
        update_crc <= (state_n >= ST_SOF) && (state_n <= ST_DATA);
        if (state_n == ST_CRC && state != ST_CRC)
          crc_hold <= crc;
      end
    end
  end

endmodule

// File: tb/tb_message_transmitter.sv
// Directed bench for message_transmitter: loops the offered bits back as the
// readback, injects ACK and faults, and compares against a frame/CRC model.
module tb_message_transmitter;

  logic        clk = 1'b0;
  logic        rst_n, tx_req, extended, rtr, bus_idle, bit_advance, rx_bit, rx_bit_valid;
  logic [28:0] msg_id;
  logic [3:0]  dlc;
  logic [63:0] msg;
  logic        next_bit, stuff_bypass, tx_busy, tx_ack, tx_done;
  logic        arb_lost, bit_error, ack_error;

  int n_checks = 0;
  int n_fail   = 0;
  int arb_cnt = 0, berr_cnt = 0, ack_cnt = 0, done_cnt = 0;
  int arb0, berr0, ack0, done0;
  int sent;
  logic done_seen, flip, pre_bit;
  logic exp_q[$];
  logic obs_q[$];

  localparam logic [10:0] STD_ID = 11'b10001010101;
  localparam logic [63:0] DATA   = 64'hd3359da81bd963e5;

  always #5 clk = ~clk;

  message_transmitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_req       (tx_req),
    .msg_id       (msg_id),
    .extended     (extended),
    .rtr          (rtr),
    .dlc          (dlc),
    .msg          (msg),
    .bus_idle     (bus_idle),
    .bit_advance  (bit_advance),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .next_bit     (next_bit),
    .stuff_bypass (stuff_bypass),
    .tx_busy      (tx_busy),
    .tx_ack       (tx_ack),
    .tx_done      (tx_done),
    .arb_lost     (arb_lost),
    .bit_error    (bit_error),
    .ack_error    (ack_error)
  );

  always @(negedge clk) begin
    if (arb_lost)  arb_cnt++;
    if (bit_error) berr_cnt++;
    if (ack_error) ack_cnt++;
    if (tx_done)   done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snapCounts;
    arb0  = arb_cnt;
    berr0 = berr_cnt;
    ack0  = ack_cnt;
    done0 = done_cnt;
  endtask

  // Reference frame: unstuffed bits from SOF to the end of intermission.
  task automatic buildFrame(input logic [28:0] id, input logic ext, input logic r,
                            input logic [3:0] d, input logic [63:0] m);
    logic [14:0] c;
    logic        nxt;
    int          n;
    exp_q.delete();
    exp_q.push_back(1'b1);
    if (ext) begin
      for (int i = 28; i >= 18; i--) exp_q.push_back(id[i]);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      for (int i = 17; i >= 0; i--) exp_q.push_back(id[i]);
      exp_q.push_back(~r);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
    end else begin
      for (int i = 10; i >= 0; i--) exp_q.push_back(id[i]);
      exp_q.push_back(~r);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
    end
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[i]);
    n = r ? 0 : ((d > 4'd8) ? 8 : int'(d));
    for (int k = 0; k < 8 * n; k++) exp_q.push_back(m[63 - k]);
    c = 15'd0;
    foreach (exp_q[j]) begin
      nxt = exp_q[j] ^ c[14];
      c   = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) exp_q.push_back(c[i]);
    repeat (13) exp_q.push_back(1'b0);
  endtask

  task automatic applyStimulus(input logic [28:0] id, input logic ext, input logic r,
                               input logic [3:0] d, input logic [63:0] m);
    buildFrame(id, ext, r, d, m);
    msg_id   = id;
    extended = ext;
    rtr      = r;
    dlc      = d;
    msg      = m;
    tx_req   = 1'b1;
    bus_idle = 1'b1;
    tick;
    checkOutput("accept_tx_ack", tx_ack, 1'b1);
    checkOutput("accept_tx_busy", tx_busy, 1'b1);
    checkOutput("accept_sof", next_bit, 1'b1);
    checkOutput("accept_bypass", stuff_bypass, 1'b0);
    tx_req = 1'b0;
    tick;
    checkOutput("tx_ack_pulse", tx_ack, 1'b0);
  endtask

  // Walks the frame; stops before presenting bit stop_pos, or right after a faulty readback.
  task automatic runBits(input int stop_pos, input int fault_pos, input logic fault_val,
                         output int n_sent, output logic done_flag);
    int   len;
    logic e;
    len       = exp_q.size();
    n_sent    = 0;
    done_flag = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 200 && !done_flag; i++) begin
      e = (i < len) ? exp_q[i] : 1'b0;
      if (i == stop_pos) return;
      checkOutput("next_bit", next_bit, e);
      checkOutput("stuff_bypass", stuff_bypass, (i >= len - 13));
      obs_q.push_back(next_bit);
      rx_bit       = (i == fault_pos) ? fault_val : ((i == len - 12) ? 1'b1 : e);
      rx_bit_valid = 1'b1;
      bit_advance  = (i == fault_pos);
      tick;
      rx_bit_valid = 1'b0;
      bit_advance  = 1'b0;
      if (i == fault_pos) return;
      tick;
      bit_advance = 1'b1;
      tick;
      bit_advance = 1'b0;
      n_sent++;
      done_flag = tx_done;
    end
  endtask

  task automatic checkAbort(input string tag);
    checkOutput({tag, "_next_bit"}, next_bit, 1'b0);
    checkOutput({tag, "_bypass"}, stuff_bypass, 1'b1);
    checkOutput({tag, "_busy"}, tx_busy, 1'b0);
    checkOutput({tag, "_done"}, tx_done, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_req       = 1'b0;
    extended     = 1'b0;
    rtr          = 1'b0;
    dlc          = 4'd0;
    msg          = 64'd0;
    msg_id       = 29'd0;
    bus_idle     = 1'b0;
    bit_advance  = 1'b0;
    rx_bit       = 1'b0;
    rx_bit_valid = 1'b0;
    repeat (3) tick;
    checkOutput("reset_next_bit", next_bit, 1'b0);
    checkOutput("reset_bypass", stuff_bypass, 1'b1);
    checkOutput("reset_busy", tx_busy, 1'b0);
    checkOutput("reset_ack", tx_ack, 1'b0);
    checkOutput("reset_done", tx_done, 1'b0);
    checkOutput("reset_errors", arb_lost | bit_error | ack_error, 1'b0);
    rst_n = 1'b1;
    tick;

    $display("[TB] standard data frame");
    snapCounts();
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(-1, -1, 1'b0, sent, done_seen);
    checkCount("std_len", sent, 111);
    checkOutput("std_done", done_seen, 1'b1);
    checkOutput("std_idle", tx_busy, 1'b0);
    tick;
    checkCount("std_done_cnt", done_cnt - done0, 1);
    checkCount("std_errors", (arb_cnt - arb0) + (berr_cnt - berr0) + (ack_cnt - ack0), 0);

    $display("[TB] extended data frame");
    snapCounts();
    applyStimulus({~STD_ID, 18'b100010101010101010}, 1'b1, 1'b0, 4'd8, DATA);
    runBits(-1, -1, 1'b0, sent, done_seen);
    checkCount("ext_len", sent, 131);
    checkOutput("ext_done", done_seen, 1'b1);
    checkOutput("ext_srr", obs_q[12], 1'b0);
    checkOutput("ext_ide", obs_q[13], 1'b0);
    checkOutput("ext_rtr", obs_q[32], 1'b1);
    checkCount("ext_errors", (arb_cnt - arb0) + (berr_cnt - berr0) + (ack_cnt - ack0), 0);

    $display("[TB] standard remote frame");
    applyStimulus({18'd0, 11'h5a3}, 1'b0, 1'b1, 4'd4, DATA);
    runBits(-1, -1, 1'b0, sent, done_seen);
    checkCount("rtr_len", sent, 47);
    checkOutput("rtr_done", done_seen, 1'b1);
    checkOutput("rtr_bit", obs_q[12], 1'b0);
    checkOutput("rtr_ide", obs_q[13], 1'b1);
    checkOutput("rtr_dlc2", obs_q[16], 1'b1);

    $display("[TB] arbitration loss and retry");
    snapCounts();
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(-1, 3, 1'b1, sent, done_seen);
    checkOutput("arb_lost_pulse", arb_lost, 1'b1);
    checkOutput("arb_no_bit_error", bit_error, 1'b0);
    checkAbort("arb");
    tx_req   = 1'b1;
    bus_idle = 1'b0;
    tick;
    checkOutput("arb_lost_clear", arb_lost, 1'b0);
    repeat (2) tick;
    checkOutput("retry_wait_busy", tx_busy, 1'b0);
    checkOutput("retry_wait_ack", tx_ack, 1'b0);
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(-1, -1, 1'b0, sent, done_seen);
    checkCount("retry_len", sent, 111);
    checkOutput("retry_done", done_seen, 1'b1);
    checkCount("arb_cnt", arb_cnt - arb0, 1);

    $display("[TB] dominant sent as recessive in ID");
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(-1, 1, 1'b0, sent, done_seen);
    checkOutput("id_bit_error", bit_error, 1'b1);
    checkOutput("id_no_arb_lost", arb_lost, 1'b0);
    checkAbort("id_err");
    tick;

    $display("[TB] missing ACK");
    snapCounts();
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(-1, 99, 1'b0, sent, done_seen);
    checkOutput("ack_error_pulse", ack_error, 1'b1);
    checkOutput("ack_no_bit_error", bit_error, 1'b0);
    checkAbort("ack");
    repeat (3) tick;
    checkCount("ack_no_done", done_cnt - done0, 0);

    $display("[TB] data bit error");
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    flip = ~exp_q[20];
    runBits(-1, 20, flip, sent, done_seen);
    checkOutput("data_bit_error", bit_error, 1'b1);
    checkOutput("data_no_arb_lost", arb_lost, 1'b0);
    checkAbort("data");
    tick;

    $display("[TB] reset in the middle of DATA");
    applyStimulus({18'd0, STD_ID}, 1'b0, 1'b0, 4'd8, DATA);
    runBits(30, -1, 1'b0, sent, done_seen);
    pre_bit = next_bit;
    checkOutput("pre_reset_bit", pre_bit, 1'b1);
    checkOutput("pre_reset_busy", tx_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_next_bit", next_bit, 1'b0);
    checkOutput("midreset_bypass", stuff_bypass, 1'b1);
    checkOutput("midreset_busy", tx_busy, 1'b0);
    checkOutput("midreset_pulses", tx_ack | tx_done | arb_lost | bit_error | ack_error, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    checkOutput("post_reset_busy", tx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/message_transmitter.md
# message_transmitter

Frame serializer for the CAN controller, the transmit counterpart of `message_reciever`. It latches a standard or extended data/remote frame request and emits the unstuffed frame bit by bit to `tx_pipeline`, from SOF through CRC, ACK slot, EOF and intermission. It computes the CRC with an instance of `crc_step_machine`, checks the destuffed bus readback from `rx_pipeline`, and reports arbitration loss, bit errors, missing ACK and completion.

## Interface
- No parameters.
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_req` in 1: level request; fields below must be stable while high.
- `msg_id` in 29: ID; standard frames use [10:0]; extended frames use [28:18] as base ID and [17:0] as extension.
- `extended` in 1: 1 selects an extended-ID frame.
- `rtr` in 1: 1 selects a remote frame (no data field).
- `dlc` in 4: transmitted as given; data bytes = min(dlc,8), or 0 when `rtr`=1.
- `msg` in 64: data bytes, MSB first from [63].
- `bus_idle` in 1: bus-idle flag from the sync/sample machine.
- `bit_advance` in 1: one-cycle pulse from `tx_pipeline` when it has consumed `next_bit`.
- `rx_bit` in 1: destuffed readback bit from `rx_pipeline`.
- `rx_bit_valid` in 1: one-cycle strobe qualifying `rx_bit`.
- `next_bit` out 1: frame bit currently offered to `tx_pipeline`. 1 is dominant and 0 is recessive, as everywhere in the design.
- `stuff_bypass` out 1: 0 from SOF through the last CRC bit, 1 otherwise.
- `tx_busy` out 1: high from accept until return to IDLE.
- `tx_ack` out 1: one-cycle pulse when the request is latched.
- `tx_done` out 1: one-cycle pulse after the last intermission bit.
- `arb_lost`, `bit_error`, `ack_error` out 1: one-cycle pulses; each forces IDLE.

## Operation
- **States:** IDLE, SOF, ID_A(11), SRR, IDE, ID_B(18), RTR, R1, R0, DLC(4), DATA(8·n), CRC(15), CRC_DEL, ACK_SLOT, ACK_DEL, EOF(7), IFS(3).
- **Field order:**
  - Standard frame: ID_A → RTR → IDE → R0 → DLC.
  - Extended frame: ID_A → SRR → IDE → ID_B → RTR → R1 → R0 → DLC.
- **Bit values:**
  - SOF = 1.
  - SRR = 0.
  - IDE = 1 for standard frames, 0 for extended frames.
  - RTR = ~rtr.
  - R1, R0 = 1.
  - CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS = 0.
- **Accept:** when IDLE and `tx_req` and `bus_idle`, the block latches all fields, pulses `clear_crc` and enters SOF.
  - `tx_req` is ignored while busy.
  - The requester drops `tx_req` after `tx_ack`. A request still high after IDLE is re-accepted, which is the retry path after an error.
- **Bit counter:** a 7-bit down-counter is loaded with field length − 1 on field entry. Each `bit_advance` decrements it or, at 0, moves to the next field.
  - DLC → CRC when the data byte count is 0.
- **CRC:**
  - Each frame bit from SOF through the last DATA/DLC bit is fed to `crc_step_machine` with a one-cycle `update_crc` when it is first presented.
  - On CRC entry, `crc[14:0]` is loaded into a shift register and sent MSB first.
- **Readback check:** on `rx_bit_valid`, `rx_bit` is compared with the bit currently on the bus, i.e. the bit presented since the most recent `bit_advance`.
  - Arbitration field (ID_A..RTR): sent 0 and read 1 gives `arb_lost`. Any other mismatch gives `bit_error`.
  - ACK_SLOT: read 0 gives `ack_error`. Read 1 is the expected ACK.
  - All other states: mismatch gives `bit_error`.
- **Completion:** the last IFS `bit_advance` gives `tx_done` and returns to IDLE.

## Timing
- **Reset values:** `next_bit`=0, `stuff_bypass`=1, all other outputs 0, state IDLE. Reset is asynchronous, including mid-frame, and the bus sees recessive immediately.
- **Accept latency:** accept in cycle t gives `tx_ack`=1, `next_bit`=1 (SOF), `stuff_bypass`=0 and `tx_busy`=1 in cycle t+1.
- **Bit latency:** `next_bit` is registered. The new bit appears in the cycle after `bit_advance`.
- **`stuff_bypass`:** rises together with CRC_DEL on `next_bit`.
- **Same-cycle `rx_bit_valid` and `bit_advance`:** the compare uses the old bit. On an error, the abort wins and there is no advance.
- **Abort:** an error pulse occurs in the cycle after the mismatched `rx_bit_valid`. In that same cycle `next_bit`=0, `stuff_bypass`=1 and `tx_busy`=0.
- **Unstuffed frame lengths:** standard frame with dlc 8 = 111 bits; extended frame with dlc 8 = 131 bits; standard remote frame = 47 bits.

## Structure
- Shared package: state enum, field-length constants (11, 18, 4, 15, 7, 3), and DOMINANT=1 / RECESSIVE=0.
- One sub-module: `crc_step_machine`, instantiated unchanged.
- No further hierarchy.

## Test plan
- **Standard data frame:** ID 11'b10001010101, dlc 8, `msg`=64'hd3359da81bd963e5, loopback through `tx_pipeline`/`rx_pipeline` with an ACK injected → 111 `bit_advance` pulses, `tx_done`; `message_reciever` reports the same ID and data and `msg_fresh`; CRC field equals the reference `crc_step_machine` result.
- **Extended frame:** `msg_id` with base ~11'b10001010101 and extension 18'b100010101010101010, dlc 8 → 131 bits; SRR and IDE sent as 0; receiver `extended`=1.
- **Remote frame:** `rtr`=1, dlc 4 → no DATA; 47 bits; RTR bit 0.
- **Arbitration loss:** force `rx_bit`=1 on the 3rd ID bit when 0 was sent → `arb_lost` 1 cycle later, `next_bit`=0, IDLE; re-accept once `bus_idle`.
- **Missing ACK:** force `rx_bit`=0 in ACK_SLOT → `ack_error`, no `tx_done`.
- **Bit error and reset mid-frame:** mismatch in DATA → `bit_error`. Assert `rst_n`=0 in DATA → all outputs return to reset values within the same cycle.
